// File: rtl/priority_scan_encoder_if.sv
// Request-in / index-out stream bundle for priority_scan_encoder.
// The slave modport is the encoder side; master is the producer/consumer side.
interface priority_scan_encoder_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_single;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_none;

    modport master (
        output in_valid, in_data, in_single, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_none
    );

    modport slave (
        input  in_valid, in_data, in_single, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_none
    );
endinterface

// File: rtl/priority_scan_encoder.sv
// Serialising priority encoder: captures a request vector, then emits the index
// of each set bit one beat at a time in priority order (or only the top one).
module priority_scan_encoder #(
    parameter int WIDTH     = 8,
    parameter int IDX_W     = 3,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    priority_scan_encoder_if.slave   bus,
    output logic                     busy
);

    if (WIDTH < 2 || IDX_W != $clog2(WIDTH)) begin : g_param_check
        $error("priority_scan_encoder: WIDTH must be >= 2 and IDX_W must be clog2(WIDTH)");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             single_q, single_d;
    logic             none_q, none_d;

    logic             scan;
    logic             in_ready_c;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] out_idx_c;
    logic             last_c;
    logic [WIDTH-1:0] sel_onehot;

    // Later iterations overwrite earlier hits, so the loop direction picks the winner.
    function automatic logic [IDX_W-1:0] find_top(input logic [WIDTH-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) begin
                if (vec[i]) idx = IDX_W'(i);
            end else begin
                if (vec[WIDTH-1-i]) idx = IDX_W'(WIDTH-1-i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_one_hot(input logic [WIDTH-1:0] vec);
        return (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);
    endfunction

    assign scan       = (state_q == SCAN);
    assign top_idx    = find_top(pending_q);
    assign out_idx_c  = (scan && !none_q) ? top_idx : '0;
    assign last_c     = scan && (none_q || single_q || is_one_hot(pending_q));
    assign sel_onehot = WIDTH'(1) << out_idx_c;
    assign in_ready_c = (state_q == IDLE) && !rst;

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = scan;
    assign bus.out_idx   = out_idx_c;
    assign bus.out_last  = last_c;
    assign bus.out_none  = scan && none_q;
    assign busy          = scan;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
        state_d   = state_q;
        pending_d = pending_q;
        single_d  = single_q;
        none_d    = none_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_c) begin
                    pending_d = bus.in_data;
                    single_d  = bus.in_single;
                    none_d    = (bus.in_data == '0);
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (bus.out_ready) begin
                    pending_d = pending_q & ~sel_onehot;
                    if (last_c) begin
                        pending_d = '0;
                        single_d  = 1'b0;
                        none_d    = 1'b0;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            single_q  <= 1'b0;
            none_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            pending_q <= pending_d;
            single_q  <= single_d;
            none_q    <= none_d;
        end
    end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Bench for priority_scan_encoder: an 8-bit MSB-first and a 16-bit LSB-first instance
// checked beat-by-beat against a list-of-indices reference model.
module tb_priority_scan_encoder;

    logic clk = 1'b0;
    logic rst;
    logic busy8, busy16;
    int   total = 0;
    int   bad   = 0;

    int   exp_q[$];
    bit   exp_none;

    always #5 clk = ~clk;

    priority_scan_encoder_if #(.WIDTH(8),  .IDX_W(3)) i8 ();
    priority_scan_encoder_if #(.WIDTH(16), .IDX_W(4)) i16 ();

    priority_scan_encoder #(.WIDTH(8), .IDX_W(3), .MSB_FIRST(1'b1)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (i8),
        .busy(busy8)
    );

    priority_scan_encoder #(.WIDTH(16), .IDX_W(4), .MSB_FIRST(1'b0)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (i16),
        .busy(busy16)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Expected beat list: set bit positions in priority order, truncated for single mode.
    task automatic build_expected(input int w, input bit msb, input logic [15:0] vec,
                                  input bit single);
        exp_q.delete();
        exp_none = 1'b0;
        for (int k = 0; k < w; k++) begin
            int p = msb ? (w - 1 - k) : k;
            if (vec[p]) exp_q.push_back(p);
        end
        if (exp_q.size() == 0) begin
            exp_none = 1'b1;
            exp_q.push_back(0);
        end
        if (single) while (exp_q.size() > 1) void'(exp_q.pop_back());
    endtask

    function automatic logic [2:0] legacy_enc8(input logic [7:0] v);
        casez (v)
            8'b1???????: return 3'd7;
            8'b01??????: return 3'd6;
            8'b001?????: return 3'd5;
            8'b0001????: return 3'd4;
            8'b00001???: return 3'd3;
            8'b000001??: return 3'd2;
            8'b0000001?: return 3'd1;
            default:     return 3'd0;
        endcase
    endfunction

    task automatic drive_in(input bit sel16, input logic valid, input logic [15:0] data,
                            input logic single);
        if (sel16) begin
            i16.in_valid  = valid;
            i16.in_data   = data;
            i16.in_single = single;
        end else begin
            i8.in_valid   = valid;
            i8.in_data    = data[7:0];
            i8.in_single  = single;
        end
    endtask

    task automatic set_ready(input bit sel16, input logic r);
        if (sel16) i16.out_ready = r;
        else       i8.out_ready  = r;
    endtask

    task automatic run_vec(input bit sel16, input logic [15:0] vec, input bit single,
                           input int stall_pct, input string name, output int first_idx);
        int       w = sel16 ? 16 : 8;
        bit       msb = !sel16;
        int       k;
        int       cycles;
        bit       rdy;
        bit       want_last;
        logic     ov, ol, on, ob, ir;
        logic [3:0] oi;
        build_expected(w, msb, vec, single);
        first_idx = -1;
        cycles = 0;
        while (!(sel16 ? i16.in_ready : i8.in_ready) && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        total++;
        if ((sel16 ? i16.in_ready : i8.in_ready) !== 1'b1) begin
            bad++;
            $display("FAIL %s accept: in_ready=%b, required 1 within 20 cycles", name,
                     sel16 ? i16.in_ready : i8.in_ready);
            return;
        end
        drive_in(sel16, 1'b1, vec, single);
        @(negedge clk);
        drive_in(sel16, 1'b0, 16'($urandom), 1'($urandom));
        k = 0;
        cycles = 0;
        while (k < exp_q.size() && cycles < 200) begin
            rdy = ($urandom_range(99) >= stall_pct);
            set_ready(sel16, rdy);
            ov = sel16 ? i16.out_valid : i8.out_valid;
            oi = sel16 ? i16.out_idx   : {1'b0, i8.out_idx};
            ol = sel16 ? i16.out_last  : i8.out_last;
            on = sel16 ? i16.out_none  : i8.out_none;
            ob = sel16 ? busy16        : busy8;
            want_last = (k == exp_q.size() - 1);
            total++;
            if (ov !== 1'b1 || ob !== 1'b1 || oi !== 4'(exp_q[k]) || ol !== want_last ||
                on !== exp_none) begin
                bad++;
                $display("FAIL %s beat%0d: valid=%b busy=%b idx=%0d last=%b none=%b, required valid=1 busy=1 idx=%0d last=%b none=%b",
                         name, k, ov, ob, oi, ol, on, exp_q[k], want_last, exp_none);
            end
            if (k == 0 && first_idx < 0) first_idx = int'(oi);
            if (rdy) k++;
            @(negedge clk);
            cycles++;
        end
        set_ready(sel16, 1'b0);
        if (k < exp_q.size()) begin
            total++;
            bad++;
            $display("FAIL %s beats: consumed=%0d, required %0d before cycle limit", name, k,
                     exp_q.size());
        end
        ov = sel16 ? i16.out_valid : i8.out_valid;
        ir = sel16 ? i16.in_ready  : i8.in_ready;
        total++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            bad++;
            $display("FAIL %s idle_after: out_valid=%b in_ready=%b, required 0 and 1", name, ov, ir);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_in(1'b0, 1'b0, 16'h0, 1'b0);
        drive_in(1'b1, 1'b0, 16'h0, 1'b0);
        set_ready(1'b0, 1'b0);
        set_ready(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        total++;
        if (i8.in_ready !== 1'b0 || i8.out_valid !== 1'b0 || busy8 !== 1'b0 ||
            i8.out_idx !== 3'd0 || i8.out_last !== 1'b0 || i8.out_none !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b idx=%0d last=%b none=%b, required all 0",
                     i8.in_ready, i8.out_valid, busy8, i8.out_idx, i8.out_last, i8.out_none);
        end
        rst = 1'b0;
        #1;
        total++;
        if (i8.in_ready !== 1'b1 || i16.in_ready !== 1'b1 || i16.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: in_ready8=%b in_ready16=%b out_valid16=%b, required 1 1 0",
                     i8.in_ready, i16.in_ready, i16.out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        int f;
        run_vec(1'b0, 16'h00A4, 1'b0, 0, "basic_a4", f);
    endtask

    task automatic test_zero();
        int f;
        run_vec(1'b0, 16'h0000, 1'b0, 0, "zero", f);
        run_vec(1'b0, 16'h0000, 1'b1, 30, "zero_single", f);
    endtask

    task automatic test_single();
        int f;
        run_vec(1'b0, 16'h0016, 1'b1, 0, "single_16", f);
        for (int v = 0; v < 256; v++) begin
            run_vec(1'b0, 16'(v), 1'b1, 20, "sweep", f);
            total++;
            if (f !== int'(legacy_enc8(8'(v)))) begin
                bad++;
                $display("FAIL legacy_eq vec=%02h: idx=%0d, required %0d", v, f, legacy_enc8(8'(v)));
            end
        end
    endtask

    task automatic test_backpressure();
        drive_in(1'b0, 1'b1, 16'h00C0, 1'b0);
        set_ready(1'b0, 1'b0);
        @(negedge clk);
        drive_in(1'b0, 1'b1, 16'h0001, 1'b1);
        for (int c = 0; c < 3; c++) begin
            total++;
            if (i8.out_valid !== 1'b1 || i8.out_idx !== 3'd7 || i8.out_last !== 1'b0 ||
                i8.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall%0d: valid=%b idx=%0d last=%b in_ready=%b, required 1 7 0 0",
                         c, i8.out_valid, i8.out_idx, i8.out_last, i8.in_ready);
            end
            @(negedge clk);
        end
        drive_in(1'b0, 1'b0, 16'h0, 1'b0);
        set_ready(1'b0, 1'b1);
        total++;
        if (i8.out_valid !== 1'b1 || i8.out_idx !== 3'd7 || i8.out_last !== 1'b0) begin
            bad++;
            $display("FAIL release_beat0: valid=%b idx=%0d last=%b, required 1 7 0",
                     i8.out_valid, i8.out_idx, i8.out_last);
        end
        @(negedge clk);
        total++;
        if (i8.out_valid !== 1'b1 || i8.out_idx !== 3'd6 || i8.out_last !== 1'b1) begin
            bad++;
            $display("FAIL release_beat1: valid=%b idx=%0d last=%b, required 1 6 1",
                     i8.out_valid, i8.out_idx, i8.out_last);
        end
        @(negedge clk);
        set_ready(1'b0, 1'b0);
        total++;
        if (i8.out_valid !== 1'b0 || i8.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_idle: out_valid=%b in_ready=%b, required 0 1", i8.out_valid, i8.in_ready);
        end
    endtask

    task automatic test_width16();
        int f;
        run_vec(1'b1, 16'h8001, 1'b0, 0, "w16_8001", f);
        run_vec(1'b1, 16'hFFFF, 1'b0, 0, "w16_ffff", f);
        run_vec(1'b1, 16'h0000, 1'b0, 0, "w16_zero", f);
    endtask

    task automatic test_reset_mid();
        int f;
        drive_in(1'b0, 1'b1, 16'h00FF, 1'b0);
        set_ready(1'b0, 1'b1);
        @(negedge clk);
        drive_in(1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        total++;
        if (i8.out_valid !== 1'b1 || i8.out_idx !== 3'd6) begin
            bad++;
            $display("FAIL mid_second_beat: valid=%b idx=%0d, required 1 6", i8.out_valid, i8.out_idx);
        end
        rst = 1'b1;
        #1;
        total++;
        if (i8.out_valid !== 1'b0 || busy8 !== 1'b0 || i8.out_last !== 1'b0 || i8.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: valid=%b busy=%b last=%b in_ready=%b, required all 0",
                     i8.out_valid, busy8, i8.out_last, i8.in_ready);
        end
        @(negedge clk);
        total++;
        if (i8.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_hold: in_ready=%b, required 0", i8.in_ready);
        end
        set_ready(1'b0, 1'b0);
        rst = 1'b0;
        #1;
        total++;
        if (i8.in_ready !== 1'b1 || i8.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_release: in_ready=%b out_valid=%b, required 1 0", i8.in_ready, i8.out_valid);
        end
        @(negedge clk);
        run_vec(1'b0, 16'h0001, 1'b0, 0, "after_reset_01", f);
    endtask

    task automatic test_random();
        int f;
        for (int n = 0; n < 60; n++) begin
            bit sel = 1'($urandom);
            logic [15:0] v = 16'($urandom);
            bit single = ($urandom_range(3) == 0);
            if ($urandom_range(7) == 0) v = 16'h0;
            run_vec(sel, v, single, 35, "random", f);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_single();
        test_backpressure();
        test_width16();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/priority_scan_encoder.md
Name: priority_scan_encoder

Overview:
Parametrised, handshaked successor to the 8-to-3 priority encoder. Accepts a WIDTH-bit request vector and emits the index of every set bit, one per output beat, in priority order. A per-vector single mode emits only the top-priority index, which reproduces classic priority-encoder behaviour. The block sits between request-collection logic and any consumer that services requests serially.

Parameters:
WIDTH, 8, request vector width; must be ≥2.
IDX_W, 3, index width; must equal clog2(WIDTH).
MSB_FIRST, 1, 1 = highest set bit has priority; 0 = lowest set bit has priority.

Ports:
clk  in  1  clock; all state on rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  in_data and in_single are valid.
in_ready  out  1  block can accept a vector.
in_data  in  WIDTH  request vector.
in_single  in  1  1 = emit only the top-priority index; sampled at accept.
out_valid  out  1  out_idx/out_last/out_none are valid.
out_ready  in  1  consumer accepts the current beat.
out_idx  out  IDX_W  index of the current highest-priority pending bit.
out_last  out  1  final beat of the current vector.
out_none  out  1  accepted vector was all-zero.
busy  out  1  a vector is being scanned.

Behaviour:
- Internal state: FSM {IDLE, SCAN}; pending[WIDTH-1:0]; single_q; none_q.
- Reset, asynchronous on rst high, applies immediately mid-operation:
  - state=IDLE; pending, single_q, none_q cleared.
  - out_valid=0, out_idx=0, out_last=0, out_none=0, busy=0.
  - in_ready=0 while rst is high.
- IDLE:
  - in_ready=1, out_valid=0, busy=0.
  - On in_valid&&in_ready: pending<=in_data, single_q<=in_single, none_q<=(in_data==0), go to SCAN.
  - in_data is not used after the accept cycle.
- SCAN:
  - in_ready=0, busy=1, out_valid=1.
  - First beat is visible the cycle after accept (latency 1).
  - Outputs are derived from registered state only; no combinational in→out path.
- out_idx:
  - MSB_FIRST=1: position of the highest set bit of pending.
  - MSB_FIRST=0: position of the lowest set bit.
  - Forced to 0 when none_q=1.
- out_none = none_q.
- out_last = 1 when any of these holds:
  - none_q=1;
  - single_q=1;
  - pending has exactly one bit set.
- Beat handshake (out_valid&&out_ready):
  - Clear bit out_idx in pending.
  - If out_last=1: clear pending and go to IDLE; in_ready=1 on the following cycle.
- Backpressure: while out_ready=0, every output stays stable and pending is unchanged.
- Throughput: one index per cycle while out_ready=1.
- Per-vector cost: popcount(in_data) beats, or 1 beat in single/none cases, plus 1 IDLE cycle.
- Overlap: no acceptance overlaps a scan. in_valid during SCAN is ignored and must be held by the producer.
- All-ones vector: WIDTH beats, indices WIDTH-1..0 (or 0..WIDTH-1 when MSB_FIRST=0).
- Width rules: priority search is a parametrised loop. No hard-coded case table; it must elaborate for any WIDTH ≥2.
- Equivalence: in_single=1 with WIDTH=8, MSB_FIRST=1 gives, for a nonzero vector, the same out_idx as the legacy 8-to-3 encoder. For a zero vector it gives out_idx=0 with out_none=1.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, in_data=8'b1010_0100, in_single=0, out_ready=1 → beats idx 7, 5, 2 on 3 consecutive cycles starting 1 cycle after accept. out_last=1 only on idx 2. in_ready=1 on the next cycle.
2. in_data=8'h00 → exactly one beat with out_idx=0, out_none=1, out_last=1; then IDLE.
3. in_single=1, in_data=8'b0001_0110 → one beat, out_idx=4, out_last=1, out_none=0. Sweep all 256 vectors against the legacy encoder's output.
4. in_data=8'b1100_0000, out_ready held 0 for 3 cycles → out_idx stays 7 with out_valid=1. Release → beats 7, 6 with last on 6. Also drive in_valid during SCAN → not accepted.
5. WIDTH=16, IDX_W=4, MSB_FIRST=0, in_data=16'h8001 → beats idx 0 then 15. Then in_data=16'hFFFF → 16 beats, idx 0..15.
6. Assert rst during the second beat of 8'hFF → out_valid, busy, out_last drop immediately; in_ready=0 while rst is high. After release, IDLE with in_ready=1. A new vector 8'h01 yields a single beat, idx 0 with last=1.
